// File: rtl/alu_pkg.sv
// Shared ALU datapath constants: look-ahead group width, pipeline stage count
// and bit positions for consumers that bundle the adder flags into one vector.
package alu_pkg;

  localparam int GROUP_W  = 4;

  localparam int FLG_CO   = 0;
  localparam int FLG_OV   = 1;
  localparam int FLG_ZERO = 2;
  localparam int FLG_NEG  = 3;
  localparam int FLG_W    = 4;

  function automatic int stage_count(input int width, input int gps);
    return width / (GROUP_W * gps);
  endfunction

endpackage

// File: rtl/cla4_gp.sv
// Purely combinational 4-bit carry look-ahead group with group generate and
// group propagate outputs, so groups can be chained by a higher-level look-ahead.
module cla4_gp
  import alu_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               ci,
  output logic [GROUP_W-1:0] sum,
  output logic [GROUP_W-1:0] carry,
  output logic               g,
  output logic               p
);

  logic [GROUP_W-1:0] gi;
  logic [GROUP_W-1:0] pi;

  assign gi = a & b;
  assign pi = a ^ b;

  // carry[i] is the carry into bit i, each expanded as a two-level sum of products
  assign carry[0] = ci;
  assign carry[1] = gi[0] | (pi[0] & ci);
  assign carry[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
  assign carry[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                  | (pi[2] & pi[1] & pi[0] & ci);

  assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
           | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p = &pi;

  assign sum = pi ^ carry;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-look-ahead adder/subtractor: GPS look-ahead groups per stage,
// one global advance signal, registered sum and flags at the last stage.
module cla_pipe_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GPS   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ov,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int NS   = stage_count(WIDTH, GPS);
  localparam int NG   = WIDTH / GROUP_W;
  localparam int SW   = GROUP_W * GPS;
  localparam int NFWD = (NS > 1) ? NS - 1 : 1;

  logic             adv;
  logic [WIDTH-1:0] op_a   [NS];
  logic [WIDTH-1:0] op_b   [NS];
  logic [WIDTH-1:0] sum_in [NS];
  logic             cin    [NS];
  logic             vld_in [NS];

  logic [WIDTH-1:0]   grp_sum;
  logic [NG-1:0]      grp_g;
  logic [NG-1:0]      grp_p;
  logic [NG-1:0]      grp_ci;
  logic [GROUP_W-1:0] grp_carry [NG];

  logic             vld_q [NS];
  logic [WIDTH-1:0] sum_q [NS];
  logic [WIDTH-1:0] a_q   [NFWD];
  logic [WIDTH-1:0] b_q   [NFWD];
  logic             c_q   [NFWD];
  logic [FLG_W-1:0] flg_q;

  // A stall anywhere freezes the whole pipe, so ready depends only on the output slot
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[NS-1];
  assign out_sum   = sum_q[NS-1];
  assign out_co    = flg_q[FLG_CO];
  assign out_ov    = flg_q[FLG_OV];
  assign out_zero  = flg_q[FLG_ZERO];
  assign out_neg   = flg_q[FLG_NEG];

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla4_gp u_grp (
      .a     (op_a[gi/GPS][gi*GROUP_W +: GROUP_W]),
      .b     (op_b[gi/GPS][gi*GROUP_W +: GROUP_W]),
      .ci    (grp_ci[gi]),
      .sum   (grp_sum[gi*GROUP_W +: GROUP_W]),
      .carry (grp_carry[gi]),
      .g     (grp_g[gi]),
      .p     (grp_p[gi])
    );
  end

  for (genvar s = 0; s < NS; s++) begin : g_stage
    localparam logic [WIDTH-1:0] LO_CUR  = {WIDTH{1'b1}} >> (WIDTH - (s + 1) * SW);
    localparam logic [WIDTH-1:0] LO_PREV = {WIDTH{1'b1}} >> (WIDTH - s * SW);
    localparam logic [WIDTH-1:0] SLICE   = LO_CUR & ~LO_PREV;

    logic [GPS:0]     cc;
    logic [WIDTH-1:0] sum_nxt;

    if (s == 0) begin : g_entry
      assign op_a[s]   = in_a;
      assign op_b[s]   = in_sub ? ~in_b : in_b;
      assign cin[s]    = in_sub | in_ci;
      assign sum_in[s] = '0;
      assign vld_in[s] = in_valid;
    end else begin : g_link
      assign op_a[s]   = a_q[s-1];
      assign op_b[s]   = b_q[s-1];
      assign cin[s]    = c_q[s-1];
      assign sum_in[s] = sum_q[s-1];
      assign vld_in[s] = vld_q[s-1];
    end

    // cc[j] is the carry into group j of this stage, each one a flat G/P product sum
    always_comb begin
      logic term;
      cc   = '0;
      term = 1'b0;
      for (int j = 0; j <= GPS; j++) begin
        cc[j] = cin[s];
        for (int i = 0; i < j; i++) cc[j] = cc[j] & grp_p[s*GPS+i];
        for (int i = 0; i < j; i++) begin
          term = grp_g[s*GPS+i];
          for (int m = i + 1; m < j; m++) term = term & grp_p[s*GPS+m];
          cc[j] = cc[j] | term;
        end
      end
    end

    for (genvar j = 0; j < GPS; j++) begin : g_ci
      assign grp_ci[s*GPS+j] = cc[j];
    end

    assign sum_nxt = sum_in[s] | (grp_sum & SLICE);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_q[s] <= 1'b0;
        sum_q[s] <= '0;
      end else if (adv) begin
        vld_q[s] <= vld_in[s];
        sum_q[s] <= sum_nxt;
      end
    end

    if (s < NS - 1) begin : g_fwd
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_q[s] <= '0;
          b_q[s] <= '0;
          c_q[s] <= 1'b0;
        end else if (adv) begin
          a_q[s] <= op_a[s] & ~LO_CUR;
          b_q[s] <= op_b[s] & ~LO_CUR;
          c_q[s] <= cc[GPS];
        end
      end
    end else begin : g_last
      // Flags come from the completed sum, so nothing from in_* reaches out_* unregistered
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          flg_q <= '0;
        end else if (adv) begin
          flg_q[FLG_CO]   <= cc[GPS];
          flg_q[FLG_OV]   <= cc[GPS] ^ grp_carry[NG-1][GROUP_W-1];
          flg_q[FLG_ZERO] <= (sum_nxt == '0);
          flg_q[FLG_NEG]  <= sum_nxt[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: the driver queues expected results at
// acceptance, an independent monitor compares them whenever out_valid is high.
module tb_cla_pipe_adder;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int G  = 2;
  localparam int NS = stage_count(W, G);

  typedef struct {
    logic [W-1:0]     sum;
    logic [FLG_W-1:0] flg;
    int               accEdge;
    int               accStall;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_ci;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_co;
  logic         out_ov;
  logic         out_zero;
  logic         out_neg;

  exp_t expQ[$];
  exp_t headE;
  int   checks = 0;
  int   passes = 0;
  int   edgeCount = 0;
  int   stallCount = 0;
  int   readyMode = 0;
  bit   seenHead = 0;

  cla_pipe_adder #(.WIDTH(W), .GPS(G)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .out_ov    (out_ov),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edgeCount++;
  end

  // Downstream ready pattern: 0 always, 1 toggling, 2 mostly ready, 3 held off
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic ci, input logic sub);
    exp_t   e;
    longint ua, ub, sa, sb, ures, sres;
    longint lim;
    lim  = longint'(1) << (W - 1);
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    e.flg = '0;
    if (sub) begin
      ures = ua - ub;
      sres = sa - sb;
      e.flg[FLG_CO] = (ua >= ub);
    end else begin
      ures = ua + ub + longint'(ci);
      sres = sa + sb + longint'(ci);
      e.flg[FLG_CO] = (ures >= (longint'(1) << W));
    end
    e.sum = W'(ures);
    e.flg[FLG_OV]   = (sres >= lim) || (sres < -lim);
    e.flg[FLG_ZERO] = (e.sum == '0);
    e.flg[FLG_NEG]  = e.sum[W-1];
    e.accEdge  = 0;
    e.accStall = 0;
    return e;
  endfunction

  function automatic exp_t mkExp(input logic [W-1:0] sum, input logic co, input logic ov,
                                 input logic zero, input logic neg);
    exp_t e;
    e.sum = sum;
    e.flg = '0;
    e.flg[FLG_CO]   = co;
    e.flg[FLG_OV]   = ov;
    e.flg[FLG_ZERO] = zero;
    e.flg[FLG_NEG]  = neg;
    e.accEdge  = 0;
    e.accStall = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] pickOperand();
    logic [W-1:0] msb;
    msb = '0;
    msb[W-1] = 1'b1;
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return msb;
      3:       return ~msb;
      default: return W'($urandom);
    endcase
  endfunction

  // Presents one operation and waits (bounded) until it is accepted
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic ci, input logic sub, input exp_t e);
    bit done;
    done = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_ci    = ci;
    in_sub   = sub;
    for (int i = 0; i < 1000 && !done; i++) begin
      #4;
      if (in_ready) begin
        e.accEdge  = edgeCount + 1;
        e.accStall = stallCount;
        expQ.push_back(e);
        done = 1;
      end
      @(posedge clk);
      if (!done) @(negedge clk);
    end
    if (!done) begin
      checks++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, expected acceptance");
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic randomOp();
    logic [W-1:0] a, b;
    logic ci, sub;
    a   = pickOperand();
    b   = pickOperand();
    ci  = $urandom_range(0, 1);
    sub = $urandom_range(0, 1);
    applyStimulus(a, b, ci, sub, refModel(a, b, ci, sub));
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_sum"}, out_sum, 0);
    checkOutput({tag, "_flags"}, {out_neg, out_zero, out_ov, out_co}, 0);
  endtask

  // Monitor samples one time unit before each rising edge
  initial forever begin
    logic [FLG_W-1:0] actFlg;
    @(negedge clk);
    #4;
    if (reset_n === 1'b1) begin
      checkOutput("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_output: got sum %0h, expected no result", out_sum);
        end else begin
          headE = expQ[0];
          if (!seenHead) begin
            seenHead = 1;
            if (stallCount == headE.accStall)
              checkOutput("latency", edgeCount, headE.accEdge + NS - 1);
          end
          actFlg = '0;
          actFlg[FLG_CO]   = out_co;
          actFlg[FLG_OV]   = out_ov;
          actFlg[FLG_ZERO] = out_zero;
          actFlg[FLG_NEG]  = out_neg;
          checkOutput("sum", out_sum, headE.sum);
          checkOutput("flags", actFlg, headE.flg);
          if (out_ready) begin
            void'(expQ.pop_front());
            seenHead = 0;
          end
        end
        if (!out_ready) stallCount++;
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 2000 && expQ.size() != 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ.size());
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_ci    = 1'b0;
    in_sub   = 1'b0;
    #1;
    checkCleared("reset");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    // Directed boundary cases with hand-derived results, one at a time
    readyMode = 0;
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mkExp(32'h0000_0000, 1, 0, 1, 0));
    idleCycles(6);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mkExp(32'h7FFF_FFFF, 1, 1, 0, 0));
    idleCycles(6);
    applyStimulus(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, mkExp(32'hFFFF_FFFF, 0, 0, 0, 1));
    idleCycles(6);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mkExp(32'h8000_0000, 0, 1, 0, 1));
    idleCycles(6);
    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, mkExp(32'h0000_0009, 0, 0, 0, 0));
    idleCycles(6);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, mkExp(32'h0000_0000, 1, 0, 1, 0));
    idleCycles(6);
    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, mkExp(32'h0000_0002, 1, 0, 0, 0));
    idleCycles(6);

    // Back-to-back stream against a toggling downstream ready
    readyMode = 1;
    for (int i = 0; i < 8; i++) randomOp();
    idleCycles(1);
    readyMode = 0;
    drain();

    // Asynchronous reset with three operations in flight and the output stalled
    readyMode = 3;
    for (int i = 0; i < 3; i++) randomOp();
    idleCycles(8);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkCleared("async_rst");
    expQ.delete();
    seenHead = 0;
    readyMode = 0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    idleCycles(4);
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, refModel(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0));
    idleCycles(6);

    // Randomized traffic with random gaps and random backpressure
    readyMode = 2;
    for (int i = 0; i < 400; i++) begin
      randomOp();
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
    end
    idleCycles(1);
    readyMode = 0;
    drain();
    idleCycles(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
